cutter_input_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the packet cutter datapath between NUM_QUEUES AXI4-Stream RX queues.
- Grants one queue at a time and forwards that queue's whole packet, tdata/tstrb/tuser/tlast unmodified, to a single master stream.
- The master stream feeds the cutter's s_axis input.
- Per-queue enable mask and packet/grant status are exposed for the register block.

---
 rtl/cutter_input_arbiter_pkg.sv | 36 +++
 rtl/cutter_input_arbiter_if.sv | 20 ++
 rtl/cutter_input_arbiter_rr_pick.sv | 24 ++
 rtl/cutter_input_arbiter.sv | 119 +++++++++++
 tb/tb_cutter_input_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cutter_input_arbiter_pkg.sv
// Shared definitions for the cutter input arbiter.
//   state_t      : arbiter FSM encoding (IDLE / FWD)
//   next_grant() : rotating-priority search over up to MAX_QUEUES requests
package cutter_input_arbiter_pkg;

  localparam int unsigned MAX_QUEUES = 8;
  localparam int unsigned MAX_QW     = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FWD  = 1'b1
  } state_t;

  // Returns 1 and the index of the first set request bit found when scanning
  // ptr, ptr+1, ... modulo n; returns 0 when no request is set.
  function automatic logic next_grant(
    input  logic [MAX_QUEUES-1:0] req,
    input  int unsigned           ptr,
    input  int unsigned           n,
    output int unsigned           idx
  );
    logic        found;
    int unsigned j;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < MAX_QUEUES; k++) begin
      j = (ptr + k) % n;
      if (k < n && !found && req[j[MAX_QW-1:0]]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/cutter_input_arbiter_if.sv
// AXI4-Stream bundle carrying N parallel lanes (N=1 for a single stream).
//   tdata/tstrb/tuser : lane q occupies slice q
//   tvalid/tlast      : one bit per lane
//   tready            : one bit per lane, driven by the sink
// Modports: master (source side), slave (sink side).
interface cutter_input_arbiter_if #(
  parameter int unsigned DW = 256,
  parameter int unsigned UW = 128,
  parameter int unsigned N  = 1
);
  logic [N*DW-1:0]   tdata;
  logic [N*DW/8-1:0] tstrb;
  logic [N*UW-1:0]   tuser;
  logic [N-1:0]      tvalid;
  logic [N-1:0]      tlast;
  logic [N-1:0]      tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/cutter_input_arbiter_rr_pick.sv
// Combinational rotating priority encoder.
//   i_req   : request vector, one bit per queue
//   i_ptr   : queue index where the search starts
//   o_grant : selected queue index (valid only when o_valid)
//   o_valid : at least one request is set
module cutter_input_arbiter_rr_pick
  import cutter_input_arbiter_pkg::*;
#(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned QW         = 2
) (
  input  logic [NUM_QUEUES-1:0] i_req,
  input  logic [QW-1:0]         i_ptr,
  output logic [QW-1:0]         o_grant,
  output logic                  o_valid
);
  int unsigned w_idx;

  always_comb begin
    w_idx   = 0;
    o_valid = next_grant(MAX_QUEUES'(i_req), int'(i_ptr), NUM_QUEUES, w_idx);
    o_grant = QW'(w_idx);
  end
endmodule

// File: rtl/cutter_input_arbiter.sv
// Packet-granular round-robin arbiter sharing the cutter datapath between
// NUM_QUEUES AXI4-Stream RX queues.
//   axi_aclk / axi_resetn : clock, asynchronous active-low reset
//   s_axis                : NUM_QUEUES-lane slave bundle from the RX queues
//   m_axis                : single-lane master stream to the cutter
//   queue_en              : per-queue arbitration enable, sampled in IDLE
//   cur_grant             : queue currently or last granted
//   busy                  : high while forwarding a packet
//   pkt_count             : packets forwarded since reset (wraps)
module cutter_input_arbiter
  import cutter_input_arbiter_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_QUEUES           = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
  localparam int unsigned QW                  = $clog2(NUM_QUEUES)
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  cutter_input_arbiter_if.slave         s_axis,
  cutter_input_arbiter_if.master        m_axis,
  input  logic [NUM_QUEUES-1:0]         queue_en,
  output logic [QW-1:0]                 cur_grant,
  output logic                          busy,
  output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_count
);
  localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;

  state_t                        r_state, w_state_nxt;
  logic [QW-1:0]                 r_rr_ptr, r_cur_grant;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_pkt_count;

  logic [NUM_QUEUES-1:0] w_req;
  logic [QW-1:0]         w_pick;
  logic                  w_pick_valid;
  logic [DW-1:0]         w_sel_data;
  logic [SW-1:0]         w_sel_strb;
  logic [UW-1:0]         w_sel_user;
  logic                  w_sel_valid, w_sel_last;
  logic                  w_last_xfer;

  assign w_req = s_axis.tvalid & queue_en;

  cutter_input_arbiter_rr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .QW         (QW)
  ) u_rr_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick),
    .o_valid (w_pick_valid)
  );

  // Slice mux for the granted queue.
  always_comb begin
    w_sel_data  = '0;
    w_sel_strb  = '0;
    w_sel_user  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      if (r_cur_grant == QW'(q)) begin
        w_sel_data  = s_axis.tdata[q*DW +: DW];
        w_sel_strb  = s_axis.tstrb[q*SW +: SW];
        w_sel_user  = s_axis.tuser[q*UW +: UW];
        w_sel_valid = s_axis.tvalid[q];
        w_sel_last  = s_axis.tlast[q];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_last_xfer    = 1'b0;
    s_axis.tready  = '0;
    m_axis.tdata   = w_sel_data;
    m_axis.tstrb   = w_sel_strb;
    m_axis.tuser   = w_sel_user;
    m_axis.tlast   = w_sel_last;
    m_axis.tvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_state_nxt = FWD;
      end
      FWD: begin
        m_axis.tvalid              = w_sel_valid;
        s_axis.tready[r_cur_grant] = m_axis.tready;
        w_last_xfer                = w_sel_valid && m_axis.tready && w_sel_last;
        if (w_last_xfer) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_cur_grant <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_valid) r_cur_grant <= w_pick;
      if (w_last_xfer) begin
        r_rr_ptr    <= (r_cur_grant == QW'(NUM_QUEUES-1)) ? '0 : r_cur_grant + QW'(1);
        r_pkt_count <= r_pkt_count + C_S_AXI_DATA_WIDTH'(1);
      end
    end
  end

  assign cur_grant = r_cur_grant;
  assign busy      = (r_state == FWD);
  assign pkt_count = r_pkt_count;
endmodule

// File: tb/tb_cutter_input_arbiter.sv
module tb_cutter_input_arbiter;
  localparam int unsigned NQ = 4;
  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NQ-1:0] queue_en;
  logic [1:0]    cur_grant;
  logic          busy;
  logic [31:0]   pkt_count;

  logic [NQ-1:0] src_valid;
  logic [3:0]    beat [NQ];
  int unsigned   plen [NQ];
  int            tests = 0;
  int            fails = 0;

  cutter_input_arbiter_if #(.DW(DW), .UW(UW), .N(NQ)) sif ();
  cutter_input_arbiter_if #(.DW(DW), .UW(UW), .N(1))  mif ();

  cutter_input_arbiter #(
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .NUM_QUEUES           (NQ),
    .C_S_AXI_DATA_WIDTH   (32)
  ) dut (
    .axi_aclk   (clk),
    .axi_resetn (rst_n),
    .s_axis     (sif.slave),
    .m_axis     (mif.master),
    .queue_en   (queue_en),
    .cur_grant  (cur_grant),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [255:0] mkdata(int unsigned q, int unsigned b);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(q*256 + b);
    return {8{w}};
  endfunction
  function automatic logic [31:0] mkstrb(int unsigned q, int unsigned b);
    return 32'hFFFF0000 | 32'(q*16 + b);
  endfunction
  function automatic logic [127:0] mkuser(int unsigned q, int unsigned b);
    return {96'h0, 32'(q*1000 + b)};
  endfunction

  // Packet sources: each queue presents beats of a plen[q]-beat packet.
  always_comb begin
    sif.tvalid = src_valid;
    for (int unsigned q = 0; q < NQ; q++) begin
      sif.tdata[q*DW +: DW]  = mkdata(q, beat[q]);
      sif.tstrb[q*32 +: 32]  = mkstrb(q, beat[q]);
      sif.tuser[q*UW +: UW]  = mkuser(q, beat[q]);
      sif.tlast[q]           = (int'(beat[q]) == int'(plen[q]) - 1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int q = 0; q < NQ; q++) begin
      if (!rst_n) beat[q] <= '0;
      else if (src_valid[q] && sif.tready[q])
        beat[q] <= (int'(beat[q]) == int'(plen[q]) - 1) ? 4'd0 : beat[q] + 4'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned expbeat;
    int unsigned cyc;
    logic        pat;

    // Reset with all queues requesting
    rst_n = 1'b0;
    queue_en = 4'b1111;
    src_valid = 4'b1111;
    for (int q = 0; q < NQ; q++) plen[q] = 2;
    mif.tready = 1'b1;
    tick(); tick();
    chk("rst_mvalid", 256'(mif.tvalid), 256'(0));
    chk("rst_sready", 256'(sif.tready), 256'(0));
    chk("rst_pktcnt", 256'(pkt_count), 256'(0));
    chk("rst_busy",   256'(busy), 256'(0));
    rst_n = 1'b1;
    tick();
    chk("first_grant", 256'(cur_grant), 256'(0));
    chk("first_sready", 256'(sif.tready), 256'(4'b0001));

    // Round robin over 8 two-beat packets
    for (int p = 0; p < 8; p++) begin
      chk("rr_grant", 256'(cur_grant), 256'(p % 4));
      chk("rr_data0", mif.tdata, mkdata(p % 4, 0));
      chk("rr_last0", 256'(mif.tlast), 256'(0));
      tick();
      chk("rr_last1", 256'(mif.tlast), 256'(1));
      chk("rr_data1", mif.tdata, mkdata(p % 4, 1));
      tick();
      chk("rr_bubble_busy", 256'(busy), 256'(0));
      chk("rr_bubble_valid", 256'(mif.tvalid), 256'(0));
      if (p == 7) src_valid = '0;
      tick();
    end
    chk("rr_pktcnt", 256'(pkt_count), 256'(8));
    chk("rr_idle", 256'(busy), 256'(0));

    // Backpressure on queue 2, 4-beat packet, tready 1,0,0,1,...
    src_valid = 4'b0100;
    plen[2] = 4;
    tick();
    chk("bp_grant", 256'(cur_grant), 256'(2));
    expbeat = 0;
    cyc = 0;
    while (expbeat < 4 && cyc < 20) begin
      pat = (cyc % 3 == 0);
      mif.tready = pat;
      #1;
      chk("bp_sready", 256'(sif.tready), 256'({1'b0, pat, 2'b00}));
      chk("bp_data", mif.tdata, mkdata(2, expbeat));
      chk("bp_strb", 256'(mif.tstrb), 256'(mkstrb(2, expbeat)));
      chk("bp_user", 256'(mif.tuser), 256'(mkuser(2, expbeat)));
      chk("bp_last", 256'(mif.tlast), 256'(expbeat == 3));
      if (pat) expbeat++;
      cyc++;
      tick();
    end
    src_valid = '0;
    mif.tready = 1'b1;
    chk("bp_beats", 256'(expbeat), 256'(4));
    chk("bp_pktcnt", 256'(pkt_count), 256'(9));
    chk("bp_idle", 256'(busy), 256'(0));

    // Wrap and skip: rr_ptr=3, queues 1 and 2 requesting
    src_valid = 4'b0110;
    plen[1] = 1;
    plen[2] = 1;
    tick();
    chk("wrap_grant1", 256'(cur_grant), 256'(1));
    chk("wrap_last", 256'(mif.tlast), 256'(1));
    chk("wrap_data", mif.tdata, mkdata(1, 0));
    tick();
    chk("wrap_bubble", 256'(busy), 256'(0));
    tick();
    chk("wrap_grant2", 256'(cur_grant), 256'(2));
    tick();
    src_valid = '0;
    chk("wrap_pktcnt", 256'(pkt_count), 256'(11));

    // Mask 1010, then clear bit 1 during queue 1's packet
    queue_en = 4'b1010;
    src_valid = 4'b1111;
    for (int q = 0; q < NQ; q++) plen[q] = 2;
    tick();
    chk("mask_grant3a", 256'(cur_grant), 256'(3));
    tick(); tick(); tick();
    chk("mask_grant1", 256'(cur_grant), 256'(1));
    queue_en = 4'b1000;
    tick();
    chk("mask_keep_grant", 256'(cur_grant), 256'(1));
    chk("mask_keep_last", 256'(mif.tlast), 256'(1));
    chk("mask_keep_sready", 256'(sif.tready), 256'(4'b0010));
    tick(); tick();
    chk("mask_grant3b", 256'(cur_grant), 256'(3));
    tick(); tick(); tick();
    chk("mask_grant3c", 256'(cur_grant), 256'(3));
    chk("mask_pktcnt", 256'(pkt_count), 256'(14));

    // Source drops tvalid mid-packet: grant held, m_axis_tvalid follows
    src_valid = 4'b0111;
    #1;
    chk("drop_mvalid", 256'(mif.tvalid), 256'(0));
    chk("drop_busy", 256'(busy), 256'(1));
    tick();
    chk("drop_hold_busy", 256'(busy), 256'(1));
    chk("drop_hold_grant", 256'(cur_grant), 256'(3));
    queue_en = 4'b1111;
    src_valid = 4'b1010;
    plen[1] = 5;
    #1;
    chk("drop_resume", 256'(mif.tvalid), 256'(1));
    tick(); tick();
    chk("drop_pktcnt", 256'(pkt_count), 256'(15));
    chk("drop_idle", 256'(busy), 256'(0));

    // Reset at beat 2 of a 5-beat packet from queue 1
    tick();
    chk("mrst_grant", 256'(cur_grant), 256'(1));
    tick();
    chk("mrst_beat2", mif.tdata, mkdata(1, 1));
    rst_n = 1'b0;
    #1;
    chk("mrst_mvalid", 256'(mif.tvalid), 256'(0));
    chk("mrst_sready", 256'(sif.tready), 256'(0));
    chk("mrst_busy", 256'(busy), 256'(0));
    chk("mrst_pktcnt", 256'(pkt_count), 256'(0));
    chk("mrst_grant0", 256'(cur_grant), 256'(0));
    src_valid = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_restart", 256'(cur_grant), 256'(0));
    chk("mrst_restart_busy", 256'(busy), 256'(1));
    chk("mrst_restart_cnt", 256'(pkt_count), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
